// File: rtl/instr_queue_if.sv
// Fetch/rename/branch-unit bus of the instruction queue.
// Carries the entry type so both ends agree on its layout.
interface instr_queue_if #(
    parameter int COB_DEPTH = 8
);
    localparam int CA = $clog2(COB_DEPTH);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [CA-1:0]        branch_tag;
        logic [COB_DEPTH-1:0] branch_mask;
    } iqueue_t;

    logic          iqueue_wen;
    iqueue_t       iqueue_wdata;
    logic          iqueue_full;
    logic          iqueue_ren;
    iqueue_t       iqueue_rdata;
    logic          iqueue_empty;
    logic          br_broadcast;
    logic          br_clean;
    logic          br_kill;
    logic [CA-1:0] br_tag;

    modport master (
        output iqueue_wen,
        output iqueue_wdata,
        output iqueue_ren,
        output br_broadcast,
        output br_clean,
        output br_kill,
        output br_tag,
        input  iqueue_full,
        input  iqueue_rdata,
        input  iqueue_empty
    );

    modport slave (
        input  iqueue_wen,
        input  iqueue_wdata,
        input  iqueue_ren,
        input  br_broadcast,
        input  br_clean,
        input  br_kill,
        input  br_tag,
        output iqueue_full,
        output iqueue_rdata,
        output iqueue_empty
    );
endinterface

// File: rtl/instr_queue.sv
// Instruction queue between fetch and rename with branch squash.
// Define IQUEUE_PERF_CTR_EN to build the performance counters.
module instr_queue #(
    parameter int DEPTH     = 16,
    parameter int COB_DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    instr_queue_if.slave  bus,
    output logic [31:0]   perf_full_cycles,
    output logic [31:0]   perf_squashed
);
    localparam int AW = $clog2(DEPTH);
    localparam int CA = $clog2(COB_DEPTH);

    typedef struct packed {
        logic [31:0]          pc;
        logic [31:0]          inst;
        logic [CA-1:0]        branch_tag;
        logic [COB_DEPTH-1:0] branch_mask;
    } iqueue_t;

    iqueue_t              mem [DEPTH];
    logic [AW:0]          head;
    logic [AW:0]          tail;
    logic [AW:0]          count;
    logic                 empty;
    logic                 full;
    logic                 kill;
    logic                 clean;
    logic                 do_pop;
    logic                 do_push;
    logic [COB_DEPTH-1:0] clr_mask;
    logic [DEPTH-1:0]     match;
    logic                 hit;
    logic [AW:0]          first;
    logic [AW:0]          keep;
    iqueue_t              wdata_c;
    iqueue_t              rdata_c;

    assign count = tail - head;
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

    assign kill  = bus.br_broadcast && bus.br_kill;
    assign clean = bus.br_broadcast && bus.br_clean
                && !bus.br_kill;

    assign do_pop  = bus.iqueue_ren && !empty;
    assign do_push = bus.iqueue_wen && !kill
                  && (!full || do_pop);

    assign clr_mask = clean
        ? (COB_DEPTH'(1) << bus.br_tag)
        : '0;

    // Mark valid entries tagged with the resolving branch.
    for (genvar g = 0; g < DEPTH; g++) begin : g_match
        logic [AW-1:0] idx;
        assign idx = head[AW-1:0] + AW'(g);
        assign match[g] = ((AW+1)'(g) < count)
            && mem[idx].branch_mask[bus.br_tag];
    end

    // Oldest squashed entry; a popped squashed head counts once.
    always_comb begin
        hit   = |match;
        first = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (match[i]) first = (AW+1)'(i);
        end
        keep = (do_pop && first == '0)
            ? (AW+1)'(1) : first;
    end

    // Forward a same-cycle clean onto read and write data.
    always_comb begin
        rdata_c = mem[head[AW-1:0]];
        rdata_c.branch_mask = rdata_c.branch_mask & ~clr_mask;
        wdata_c = bus.iqueue_wdata;
        wdata_c.branch_mask = wdata_c.branch_mask & ~clr_mask;
    end

    assign bus.iqueue_rdata = rdata_c;
    assign bus.iqueue_empty = empty;
    assign bus.iqueue_full  = full;

    // Entry storage: write at tail, clear resolved mask bits.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (do_push && tail[AW-1:0] == AW'(i)) begin
                mem[i] <= wdata_c;
            end else if (clean) begin
                mem[i].branch_mask <=
                    mem[i].branch_mask & ~clr_mask;
            end
        end
    end

    // Head/tail pointers; kill rewinds tail to the squash point.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (do_pop) head <= head + (AW+1)'(1);
            if (kill) begin
                if (hit) tail <= head + keep;
            end else if (do_push) begin
                tail <= tail + (AW+1)'(1);
            end
        end
    end

`ifdef IQUEUE_PERF_CTR_EN
    logic [31:0] full_cnt;
    logic [31:0] sq_cnt;
    logic [AW:0] sq_num;

    assign sq_num = (kill && hit) ? (count - keep) : '0;

    // Saturating full-stall count and squashed-entry total.
    always_ff @(posedge clk) begin
        if (!rst) begin
            full_cnt <= '0;
            sq_cnt   <= '0;
        end else begin
            if (full && bus.iqueue_wen && full_cnt != '1) begin
                full_cnt <= full_cnt + 32'd1;
            end
            sq_cnt <= sq_cnt + 32'(sq_num);
        end
    end

    assign perf_full_cycles = full_cnt;
    assign perf_squashed    = sq_cnt;
`else
    assign perf_full_cycles = '0;
    assign perf_squashed    = '0;
`endif
endmodule

// File: tb/tb_instr_queue.sv
// Directed self-checking bench for instr_queue.
// Expected values are hand-derived per scenario.
module tb_instr_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pfc;
    logic [31:0] psq;
    int          checks = 0;
    int          errors = 0;

    instr_queue_if #(.COB_DEPTH(8)) bus ();

    instr_queue #(
        .DEPTH(16),
        .COB_DEPTH(8)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .bus              (bus.slave),
        .perf_full_cycles (pfc),
        .perf_squashed    (psq)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic idle();
        bus.iqueue_wen   = 1'b0;
        bus.iqueue_ren   = 1'b0;
        bus.br_broadcast = 1'b0;
        bus.br_clean     = 1'b0;
        bus.br_kill      = 1'b0;
        bus.br_tag       = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_w(input logic [31:0] pc,
                         input logic [7:0] m);
        bus.iqueue_wdata.pc          = pc;
        bus.iqueue_wdata.inst        = ~pc;
        bus.iqueue_wdata.branch_tag  = '0;
        bus.iqueue_wdata.branch_mask = m;
    endtask

    task automatic push(input logic [31:0] pc,
                        input logic [7:0] m);
        set_w(pc, m);
        bus.iqueue_wen = 1'b1;
        step();
        bus.iqueue_wen = 1'b0;
    endtask

    task automatic pop();
        bus.iqueue_ren = 1'b1;
        step();
        bus.iqueue_ren = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        set_w(32'h0, 8'h0);
        rst = 1'b0;
        bus.iqueue_wen = 1'b1;
        step();
        step();
        rst = 1'b1;
        idle();
        #1;
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL reset_empty: got %b want 1",
                     bus.iqueue_empty);
        end
        checks++;
        if (bus.iqueue_full !== 1'b0) begin
            errors++;
            $display("FAIL reset_full: got %b want 0",
                     bus.iqueue_full);
        end
        checks++;
        if (pfc !== 32'd0 || psq !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d want 0/0",
                     pfc, psq);
        end
    endtask

    task automatic test_latency();
        set_w(32'h1000, 8'h0);
        bus.iqueue_wen = 1'b1;
        #1;
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL lat_empty_n: got %b want 1",
                     bus.iqueue_empty);
        end
        step();
        bus.iqueue_wen = 1'b0;
        checks++;
        if (bus.iqueue_empty !== 1'b0) begin
            errors++;
            $display("FAIL lat_empty_n1: got %b want 0",
                     bus.iqueue_empty);
        end
        checks++;
        if (bus.iqueue_rdata.pc !== 32'h1000) begin
            errors++;
            $display("FAIL lat_pc: got %h want 00001000",
                     bus.iqueue_rdata.pc);
        end
        pop();
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL lat_drain: got %b want 1",
                     bus.iqueue_empty);
        end
    endtask

    task automatic test_full();
        logic [31:0] exp;
        for (int i = 0; i < 16; i++) begin
            push(32'h2000 + 32'(4 * i), 8'h0);
        end
        checks++;
        if (bus.iqueue_full !== 1'b1) begin
            errors++;
            $display("FAIL full_set: got %b want 1",
                     bus.iqueue_full);
        end
        set_w(32'h3000, 8'h0);
        bus.iqueue_wen = 1'b1;
        bus.iqueue_ren = 1'b1;
        step();
        idle();
        checks++;
        if (bus.iqueue_full !== 1'b1) begin
            errors++;
            $display("FAIL full_rw: got %b want 1",
                     bus.iqueue_full);
        end
        for (int i = 1; i <= 16; i++) begin
            exp = (i == 16) ? 32'h3000
                            : 32'h2000 + 32'(4 * i);
            checks++;
            if (bus.iqueue_rdata.pc !== exp) begin
                errors++;
                $display("FAIL full_order[%0d]: got %h want %h",
                         i, bus.iqueue_rdata.pc, exp);
            end
            pop();
        end
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL full_drain: got %b want 1",
                     bus.iqueue_empty);
        end
    endtask

    task automatic test_kill();
        logic [31:0] exp [3];
        exp[0] = 32'hA0;
        exp[1] = 32'hA1;
        exp[2] = 32'hC0;
        push(32'hA0, 8'h00);
        push(32'hA1, 8'h00);
        push(32'hA2, 8'h02);
        push(32'hA3, 8'h02);
        bus.br_kill = 1'b1;
        bus.br_tag  = 3'd1;
        step();
        bus.br_broadcast = 1'b1;
        set_w(32'hBAD, 8'h0);
        bus.iqueue_wen = 1'b1;
        step();
        idle();
        push(32'hC0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.iqueue_rdata.pc !== exp[i]) begin
                errors++;
                $display("FAIL kill_order[%0d]: got %h want %h",
                         i, bus.iqueue_rdata.pc, exp[i]);
            end
            pop();
        end
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL kill_drain: got %b want 1",
                     bus.iqueue_empty);
        end
    endtask

    task automatic test_clean();
        push(32'hD0, 8'h04);
        push(32'hD1, 8'h06);
        push(32'hD2, 8'h04);
        bus.iqueue_ren   = 1'b1;
        bus.br_broadcast = 1'b1;
        bus.br_clean     = 1'b1;
        bus.br_tag       = 3'd2;
        set_w(32'hD3, 8'h04);
        bus.iqueue_wen = 1'b1;
        #1;
        checks++;
        if (bus.iqueue_rdata.branch_mask !== 8'h00
            || bus.iqueue_rdata.pc !== 32'hD0) begin
            errors++;
            $display("FAIL clean_fwd: got %h/%h want D0/00",
                     bus.iqueue_rdata.pc,
                     bus.iqueue_rdata.branch_mask);
        end
        step();
        idle();
        checks++;
        if (bus.iqueue_rdata.pc !== 32'hD1
            || bus.iqueue_rdata.branch_mask !== 8'h02) begin
            errors++;
            $display("FAIL clean_d1: got %h/%h want D1/02",
                     bus.iqueue_rdata.pc,
                     bus.iqueue_rdata.branch_mask);
        end
        pop();
        checks++;
        if (bus.iqueue_rdata.pc !== 32'hD2
            || bus.iqueue_rdata.branch_mask !== 8'h00) begin
            errors++;
            $display("FAIL clean_d2: got %h/%h want D2/00",
                     bus.iqueue_rdata.pc,
                     bus.iqueue_rdata.branch_mask);
        end
        pop();
        checks++;
        if (bus.iqueue_rdata.pc !== 32'hD3
            || bus.iqueue_rdata.branch_mask !== 8'h00) begin
            errors++;
            $display("FAIL clean_wr: got %h/%h want D3/00",
                     bus.iqueue_rdata.pc,
                     bus.iqueue_rdata.branch_mask);
        end
        pop();
        push(32'hE0, 8'h02);
        bus.br_broadcast = 1'b1;
        bus.br_clean     = 1'b1;
        bus.br_kill      = 1'b1;
        bus.br_tag       = 3'd1;
        step();
        idle();
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL clean_kill: got %b want 1",
                     bus.iqueue_empty);
        end
    endtask

    task automatic kill_pop(input logic [2:0] tag);
        bus.iqueue_ren   = 1'b1;
        bus.br_broadcast = 1'b1;
        bus.br_kill      = 1'b1;
        bus.br_tag       = tag;
        step();
        idle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20; i++) begin
            push(32'h4000 + 32'(i), 8'h0);
            pop();
        end
        push(32'hF0, 8'h00);
        push(32'hF1, 8'h00);
        push(32'hF2, 8'h01);
        kill_pop(3'd0);
        checks++;
        if (bus.iqueue_rdata.pc !== 32'hF1
            || bus.iqueue_empty !== 1'b0) begin
            errors++;
            $display("FAIL wrap_keep: got %h/%b want F1/0",
                     bus.iqueue_rdata.pc, bus.iqueue_empty);
        end
        pop();
        push(32'hE0, 8'h00);
        push(32'hE1, 8'h01);
        push(32'hE2, 8'h01);
        kill_pop(3'd0);
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL wrap_popkeep: got %b want 1",
                     bus.iqueue_empty);
        end
        push(32'hB0, 8'h01);
        push(32'hB1, 8'h01);
        push(32'hB2, 8'h01);
        kill_pop(3'd0);
        checks++;
        if (bus.iqueue_empty !== 1'b1
            || bus.iqueue_full !== 1'b0) begin
            errors++;
            $display("FAIL wrap_all: got %b/%b want 1/0",
                     bus.iqueue_empty, bus.iqueue_full);
        end
        push(32'hB9, 8'h00);
        checks++;
        if (bus.iqueue_rdata.pc !== 32'hB9) begin
            errors++;
            $display("FAIL wrap_after: got %h want B9",
                     bus.iqueue_rdata.pc);
        end
        pop();
    endtask

    task automatic test_perf();
        logic [31:0] want_f;
        logic [31:0] want_s;
`ifdef IQUEUE_PERF_CTR_EN
        want_f = 32'd5;
        want_s = 32'd3;
`else
        want_f = 32'd0;
        want_s = 32'd0;
`endif
        push(32'h77, 8'h01);
        push(32'h78, 8'h01);
        rst = 1'b0;
        bus.iqueue_ren = 1'b1;
        kill_pop(3'd0);
        rst = 1'b1;
        checks++;
        if (bus.iqueue_empty !== 1'b1 || psq !== 32'd0) begin
            errors++;
            $display("FAIL perf_rst: got %b/%0d want 1/0",
                     bus.iqueue_empty, psq);
        end
        for (int i = 0; i < 16; i++) begin
            push(32'h5000 + 32'(4 * i),
                 (i >= 13) ? 8'h08 : 8'h00);
        end
        for (int i = 0; i < 5; i++) begin
            push(32'hEEE, 8'h08);
        end
        checks++;
        if (bus.iqueue_full !== 1'b1) begin
            errors++;
            $display("FAIL perf_full: got %b want 1",
                     bus.iqueue_full);
        end
        bus.br_broadcast = 1'b1;
        bus.br_kill      = 1'b1;
        bus.br_tag       = 3'd3;
        step();
        idle();
        checks++;
        if (pfc !== want_f) begin
            errors++;
            $display("FAIL perf_full_cycles: got %0d want %0d",
                     pfc, want_f);
        end
        checks++;
        if (psq !== want_s) begin
            errors++;
            $display("FAIL perf_squashed: got %0d want %0d",
                     psq, want_s);
        end
        for (int i = 0; i < 13; i++) begin
            checks++;
            if (bus.iqueue_rdata.pc !== 32'h5000 + 32'(4 * i)) begin
                errors++;
                $display("FAIL perf_rem[%0d]: got %h want %h",
                         i, bus.iqueue_rdata.pc,
                         32'h5000 + 32'(4 * i));
            end
            pop();
        end
        checks++;
        if (bus.iqueue_empty !== 1'b1) begin
            errors++;
            $display("FAIL perf_drain: got %b want 1",
                     bus.iqueue_empty);
        end
    endtask

    initial begin
        idle();
        set_w(32'h0, 8'h0);
        test_reset();
        test_latency();
        test_full();
        test_kill();
        test_clean();
        test_wrap();
        test_perf();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 16 (power of two, >= 4), number of queue entries.
REQ-002 SHALL provide parameter COB_DEPTH, default 8, branch-mask width; COB_ADDR_WIDTH = log2(COB_DEPTH).
REQ-003 SHALL have ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-low.
- iqueue_wen  in  1  fetch write request.
- iqueue_wdata  in  iqueue_t  {pc[31:0], inst[31:0], branch_tag[COB_ADDR_WIDTH-1:0], branch_mask[COB_DEPTH-1:0]}.
- iqueue_full  out  1  no free entry.
- iqueue_ren  in  1  rename pop request.
- iqueue_rdata  out  iqueue_t  head entry.
- iqueue_empty  out  1  no valid entry.
- br_broadcast  in  1  branch resolution valid.
- br_clean  in  1  branch predicted correctly.
- br_kill  in  1  branch mispredicted.
- br_tag  in  COB_ADDR_WIDTH  resolving branch tag.
- perf_full_cycles  out  32  full-cycle counter.
- perf_squashed  out  32  killed-entry counter.

Function
REQ-004 SHALL be a circular FIFO with head/tail pointers of log2(DEPTH)+1 bits; the MSB is the wrap bit. Count = tail - head, modulo 2^(log2(DEPTH)+1).
REQ-005 SHALL drive iqueue_empty = (count == 0) and iqueue_full = (count == DEPTH), both purely from registered pointers.
REQ-006 SHALL drive iqueue_rdata combinationally from the head entry; its value is don't-care when empty.
REQ-007 SHALL write iqueue_wdata at tail and advance tail by 1 when iqueue_wen && !iqueue_full; iqueue_wen while full is ignored, with no state change.
REQ-008 SHALL remove the head entry and advance head by 1 when iqueue_ren && !iqueue_empty; iqueue_ren while empty is ignored.
REQ-009 SHALL accept a simultaneous read and write when full: the pop frees a slot the same cycle, so the write is accepted and count is unchanged.
REQ-010 SHALL, on br_broadcast && br_clean, clear branch_mask[br_tag] in every stored entry and in the accepted write data; iqueue_rdata SHALL reflect the cleared bit in the same cycle (combinational forward).
REQ-011 SHALL, on br_broadcast && br_kill, squash all stored entries with branch_mask[br_tag] == 1:
- These entries form a contiguous youngest suffix.
- tail SHALL rewind to the index of the oldest squashed entry.
- If no entry matches, tail is unchanged.
REQ-012 SHALL drop any write arriving in a kill cycle (wrong path); iqueue_full is not consulted.
REQ-013 SHALL honour a pop in a kill cycle: head advances first.
- If the popped head is itself squashed, it is removed only once.
- The resulting count is never negative.
- When all entries are squashed, the queue is empty the next cycle.
REQ-014 SHALL treat br_clean && br_kill asserted together as kill only.
REQ-015 SHALL ignore br_clean/br_kill when br_broadcast is low.
REQ-016 SHALL have a latency of one cycle: an entry written in cycle N is visible on iqueue_rdata, with iqueue_empty low, in cycle N+1. There is no empty bypass.

Reset
REQ-017 SHALL, when rst == 0 at a clk edge, clear head, tail and both perf counters. Result: iqueue_empty = 1, iqueue_full = 0.
REQ-018 SHALL give reset priority over all writes, pops and broadcasts in the same cycle, including reset in the middle of a kill.
REQ-019 SHALL leave entry storage contents uninitialised; only pointers and counters are reset.

Configuration
REQ-020 SHALL compile the performance counters only when IQUEUE_PERF_CTR_EN is defined:
- perf_full_cycles increments (saturating at 2^32-1) each cycle iqueue_full && iqueue_wen.
- perf_squashed adds the number of entries squashed each kill cycle.
- Without the macro, both outputs SHALL be tied to 0 and no counter flops SHALL exist.

Verification
REQ-021 Reset then 1 write (pc=0x1000) -> iqueue_empty=1 at the write cycle, 0 the next cycle; iqueue_rdata.pc=0x1000.
REQ-022 Fill 16 entries, then wen && ren together -> iqueue_full stays 1, and the 17th entry lands with pops in FIFO order.
REQ-023 Entries with masks 0x00, 0x00, 0x02, 0x02, then kill with tag=1 -> count drops 4->2, tail rewinds by 2, and the next write occupies the old entry-3 slot.
REQ-024 Head mask=0x04, clean with tag=2 in the same cycle as a pop -> iqueue_rdata.branch_mask=0x00 that cycle; stored younger entries also clear bit 2.
REQ-025 Wrap-around: 40 writes/pops interleaved, then kill that matches all 3 entries while ren=1 -> iqueue_empty=1 next cycle.
REQ-026 With IQUEUE_PERF_CTR_EN defined: 5 cycles of wen while full, then a kill squashing 3 entries -> perf_full_cycles=5 and perf_squashed=3. Without the macro, both read 0.
